rst_sequencer: RTL and testbench

Sequences reset for the AHB subsystem's reset domains (e.g. interconnect, masters, slaves). Starts from a single already-synchronized system reset and drives one active-high reset per domain. All domain resets assert together; they release one at a time in fixed order, after a minimum hold and with a fixed gap between domains. In addition to power-on reset, it services software and watchdog reset requests, with an optional bus-quiesce handshake before a software reset.

---
 rtl/rst_seq_pkg.sv | 26 ++
 rtl/rst_seq_timer.sv | 27 ++
 rtl/rst_sequencer.sv | 172 +++++++++++++++++
 tb/tb_rst_sequencer.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/rst_seq_pkg.sv
// Shared types and helpers for the AHB reset sequencer.
package rst_seq_pkg;

    typedef enum logic [1:0] {
        HOLD    = 2'b00,
        RELEASE = 2'b01,
        RUN     = 2'b10,
        QUIESCE = 2'b11
    } state_t;

    typedef enum logic [1:0] {
        CAUSE_POR   = 2'b00,
        CAUSE_SW    = 2'b01,
        CAUSE_WDT   = 2'b10,
        CAUSE_SW_TO = 2'b11
    } cause_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/rst_seq_timer.sv
// Clearable up-counter with a terminal-compare flag; one instance serves the
// hold, gap and quiesce timeouts since only one is ever active at a time.
module rst_seq_timer #(
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic [CNT_W-1:0] term,
    output logic             hit
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign hit = (cnt == term);

endmodule

// File: rtl/rst_sequencer.sv
// Reset sequencer: asserts all domain resets together, releases them in index
// order, and services software (with bus quiesce) and watchdog reset requests.
module rst_sequencer
    import rst_seq_pkg::*;
#(
    parameter int N_DOM       = 3,
    parameter int HOLD_CYCLES = 16,
    parameter int GAP_CYCLES  = 4,
    parameter int QTO_CYCLES  = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sw_rst_req,
    input  logic             wdt_rst_req,
    input  logic             quiesce_ack,
    output logic             quiesce_req,
    output logic [N_DOM-1:0] dom_rst,
    output logic             rst_done,
    output logic             busy,
    output logic [1:0]       rst_cause
);

    localparam int CNT_MAX = max3(HOLD_CYCLES, GAP_CYCLES, QTO_CYCLES);
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int IDX_W   = $clog2(N_DOM + 1);

    localparam logic [CNT_W-1:0] HOLD_TERM = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_TERM  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] QTO_TERM  = CNT_W'(QTO_CYCLES - 1);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [N_DOM-1:0] dom_rst_q, dom_rst_d;
    logic             qreq_q, qreq_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
    cause_t           cause_q, cause_d;

    logic             cnt_clr;
    logic [CNT_W-1:0] cnt_term;
    logic             cnt_hit;
    logic             enter_hold;
    cause_t           hold_cause;

    rst_seq_timer #(
        .CNT_W(CNT_W)
    ) u_timer (
        .clk  (clk),
        .rst  (rst),
        .clr  (cnt_clr),
        .term (cnt_term),
        .hit  (cnt_hit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= HOLD;
            idx_q     <= '0;
            dom_rst_q <= '1;
            qreq_q    <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b1;
            cause_q   <= CAUSE_POR;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            dom_rst_q <= dom_rst_d;
            qreq_q    <= qreq_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
            cause_q   <= cause_d;
        end
    end

    // Every path back to HOLD funnels through enter_hold so the re-assert
    // behaviour is identical whatever triggered it.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        dom_rst_d  = dom_rst_q;
        qreq_d     = qreq_q;
        done_d     = done_q;
        busy_d     = busy_q;
        cause_d    = cause_q;
        cnt_clr    = 1'b0;
        cnt_term   = '0;
        enter_hold = 1'b0;
        hold_cause = cause_q;

        unique case (state_q)
            HOLD: begin
                cnt_term = HOLD_TERM;
                if (wdt_rst_req) begin
                    enter_hold = 1'b1;
                    hold_cause = CAUSE_WDT;
                end else if (cnt_hit) begin
                    dom_rst_d[0] = 1'b0;
                    idx_d        = IDX_W'(1);
                    cnt_clr      = 1'b1;
                    state_d      = RELEASE;
                end
            end
            RELEASE: begin
                cnt_term = GAP_TERM;
                if (wdt_rst_req) begin
                    enter_hold = 1'b1;
                    hold_cause = CAUSE_WDT;
                end else if (cnt_hit) begin
                    cnt_clr = 1'b1;
                    if (idx_q < IDX_W'(N_DOM)) begin
                        for (int i = 0; i < N_DOM; i++) begin
                            if (idx_q == IDX_W'(i)) dom_rst_d[i] = 1'b0;
                        end
                        idx_d = idx_q + IDX_W'(1);
                    end else begin
                        state_d = RUN;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end
                end
            end
            RUN: begin
                // Counter parked at zero so QUIESCE always starts a fresh timeout.
                cnt_clr = 1'b1;
                if (wdt_rst_req) begin
                    enter_hold = 1'b1;
                    hold_cause = CAUSE_WDT;
                end else if (sw_rst_req) begin
                    state_d = QUIESCE;
                    qreq_d  = 1'b1;
                    done_d  = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            QUIESCE: begin
                cnt_term = QTO_TERM;
                if (wdt_rst_req) begin
                    enter_hold = 1'b1;
                    hold_cause = CAUSE_WDT;
                end else if (quiesce_ack) begin
                    enter_hold = 1'b1;
                    hold_cause = CAUSE_SW;
                end else if (cnt_hit) begin
                    enter_hold = 1'b1;
                    hold_cause = CAUSE_SW_TO;
                end
            end
            default: begin
                enter_hold = 1'b1;
                hold_cause = CAUSE_POR;
            end
        endcase

        if (enter_hold) begin
            state_d   = HOLD;
            idx_d     = '0;
            dom_rst_d = '1;
            qreq_d    = 1'b0;
            done_d    = 1'b0;
            busy_d    = 1'b1;
            cnt_clr   = 1'b1;
            cause_d   = hold_cause;
        end
    end

    assign quiesce_req = qreq_q;
    assign dom_rst     = dom_rst_q;
    assign rst_done    = done_q;
    assign busy        = busy_q;
    assign rst_cause   = cause_q;

endmodule

// File: tb/tb_rst_sequencer.sv
// Bench for rst_sequencer: directed scenarios then random requests, checked
// every cycle against a timestamp-based model of the release schedule.
module tb_rst_sequencer;

    localparam int N_DOM       = 3;
    localparam int HOLD_CYCLES = 16;
    localparam int GAP_CYCLES  = 4;
    localparam int QTO_CYCLES  = 64;
    localparam int DONE_AT     = HOLD_CYCLES + N_DOM * GAP_CYCLES;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             sw_rst_req = 1'b0;
    logic             wdt_rst_req = 1'b0;
    logic             quiesce_ack = 1'b0;
    logic             quiesce_req;
    logic [N_DOM-1:0] dom_rst;
    logic             rst_done;
    logic             busy;
    logic [1:0]       rst_cause;

    int total = 0;
    int bad   = 0;

    int         t         = 0;
    int         seq_start = 0;
    int         q_start   = 0;
    bit         quiescing = 1'b0;
    logic [1:0] exp_cause = 2'b00;

    rst_sequencer #(
        .N_DOM       (N_DOM),
        .HOLD_CYCLES (HOLD_CYCLES),
        .GAP_CYCLES  (GAP_CYCLES),
        .QTO_CYCLES  (QTO_CYCLES)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .sw_rst_req  (sw_rst_req),
        .wdt_rst_req (wdt_rst_req),
        .quiesce_ack (quiesce_ack),
        .quiesce_req (quiesce_req),
        .dom_rst     (dom_rst),
        .rst_done    (rst_done),
        .busy        (busy),
        .rst_cause   (rst_cause)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s t=%0d observed=%0h expected=%0h", tag, t, obs, exp);
        end
    endtask

    // The model remembers only when the current hold began and when quiesce began;
    // every output is derived from elapsed edges against the schedule.
    task automatic model_edge(input bit r, input bit s, input bit w, input bit a);
        bit run_prev;
        run_prev = !quiescing && ((t - 1 - seq_start) >= DONE_AT);
        if (r) begin
            seq_start = t; quiescing = 1'b0; exp_cause = 2'b00;
        end else if (w) begin
            seq_start = t; quiescing = 1'b0; exp_cause = 2'b10;
        end else if (quiescing) begin
            if (a) begin
                seq_start = t; quiescing = 1'b0; exp_cause = 2'b01;
            end else if (t - q_start == QTO_CYCLES) begin
                seq_start = t; quiescing = 1'b0; exp_cause = 2'b11;
            end
        end else if (run_prev && s) begin
            quiescing = 1'b1; q_start = t;
        end
    endtask

    task automatic check_outputs();
        logic [N_DOM-1:0] exp_dom;
        logic             exp_done;
        int               elapsed;
        elapsed = t - seq_start;
        for (int i = 0; i < N_DOM; i++) begin
            exp_dom[i] = !quiescing && (elapsed < HOLD_CYCLES + i * GAP_CYCLES);
        end
        exp_done = !quiescing && (elapsed >= DONE_AT);
        check("dom_rst", 32'(dom_rst), 32'(exp_dom));
        check("rst_done", 32'(rst_done), 32'(exp_done));
        check("busy", 32'(busy), 32'(!exp_done));
        check("quiesce_req", 32'(quiesce_req), 32'(quiescing));
        check("rst_cause", 32'(rst_cause), 32'(exp_cause));
    endtask

    task automatic applyStimulus(input bit r, input bit s, input bit w, input bit a);
        rst         = r;
        sw_rst_req  = s;
        wdt_rst_req = w;
        quiesce_ack = a;
        @(posedge clk);
        t++;
        model_edge(r, s, w, a);
        #1;
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #1;
        // Power-on reset and first release, with ignored sw pulses in HOLD/RELEASE.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        idle(4);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        idle(12);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        idle(15);
        check("por_dom_released", 32'(dom_rst), 32'h0);
        check("por_done", 32'(rst_done), 32'h1);

        // Software reset acknowledged five cycles after the request.
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        idle(4);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        idle(DONE_AT + 2);
        check("sw_ack_cause", 32'(rst_cause), 32'h1);

        // Software reset with no acknowledge: timeout path.
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        idle(QTO_CYCLES + DONE_AT + 2);
        check("sw_to_cause", 32'(rst_cause), 32'h3);

        // Simultaneous sw and wdt: watchdog wins, no quiesce.
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        check("both_no_qreq", 32'(quiesce_req), 32'h0);
        idle(21);
        // Watchdog at edge 22 of the release restarts the hold.
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        check("wdt_rel_dom", 32'(dom_rst), 32'h7);
        idle(DONE_AT + 2);

        // Reset during QUIESCE with the counter at 30.
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        idle(30);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        check("rst_mid_q_dom", 32'(dom_rst), 32'h7);
        check("rst_mid_q_cause", 32'(rst_cause), 32'h0);
        idle(DONE_AT + 2);

        // Random requests.
        for (int i = 0; i < 3000; i++) begin
            applyStimulus(($urandom_range(0, 399) == 0),
                          ($urandom_range(0, 7) == 0),
                          ($urandom_range(0, 59) == 0),
                          ($urandom_range(0, 11) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
